// File: rtl/updown_prescaled_counter_if.sv
// Bus bundle for updown_prescaled_counter: control/data inputs and counter
// status outputs. The counter takes the slave view. Whatever drives the
// counter's controls takes the master view.
interface updown_prescaled_counter_if #(
  parameter int N          = 32,
  parameter int PRESCALE_W = 8
);
  logic                  enable;
  logic                  dec;
  logic                  load;
  logic [N-1:0]          load_value;
  logic [N-1:0]          threshold_value;
  logic                  sat_mode;
  logic [PRESCALE_W-1:0] prescale;
  logic                  clr_flags;
  logic [N-1:0]          count;
  logic                  threshold;
  logic                  tc_pulse;
  logic                  ovf_sticky;

  modport master (
    output enable, dec, load, load_value, threshold_value,
           sat_mode, prescale, clr_flags,
    input  count, threshold, tc_pulse, ovf_sticky
  );

  modport slave (
    input  enable, dec, load, load_value, threshold_value,
           sat_mode, prescale, clr_flags,
    output count, threshold, tc_pulse, ovf_sticky
  );
endinterface

// File: rtl/updown_prescaled_counter.sv
// General-purpose up/down event counter with a programmable prescaler,
// parallel load, wrap or saturate behaviour at the limits, a live threshold
// compare and limit-event reporting (one-cycle pulse plus sticky flag).
module updown_prescaled_counter #(
  parameter int N          = 32,
  parameter int PRESCALE_W = 8
) (
  input logic                    clock,
  input logic                    reset,
  updown_prescaled_counter_if.slave bus
);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [PRESCALE_W-1:0] pre_cnt_next;
  logic [N-1:0]          count_q;
  logic [N-1:0]          count_next;
  logic                  tc_q;
  logic                  ovf_q;
  logic                  step;
  logic                  at_max;
  logic                  at_min;
  logic                  limit_event;

  // A count step happens when the prescaler has reached the programmed
  // value on an enabled cycle. A load always takes precedence over a step.
  // The limit flags look at the registered count and the sampled direction.
  always_comb begin
    step        = bus.enable && !bus.load && (pre_cnt == bus.prescale);
    at_max      = (count_q == {N{1'b1}});
    at_min      = (count_q == {N{1'b0}});
    limit_event = step && (bus.dec ? at_min : at_max);
  end

  // Prescaler restarts on load and on every match. Otherwise it counts
  // enabled cycles and wraps naturally. So a prescale lowered below the
  // current pre_cnt runs all the way round before the next match.
  always_comb begin
    pre_cnt_next = pre_cnt;
    if (bus.load) begin
      pre_cnt_next = '0;
    end else if (bus.enable) begin
      if (pre_cnt == bus.prescale) begin
        pre_cnt_next = '0;
      end else begin
        pre_cnt_next = pre_cnt + 1'b1;
      end
    end
  end

  // Next count: load beats step. At a limit, the count either wraps to the
  // opposite end or holds, depending on sat_mode.
  always_comb begin
    count_next = count_q;
    if (bus.load) begin
      count_next = bus.load_value;
    end else if (step) begin
      if (limit_event) begin
        if (!bus.sat_mode) begin
          count_next = bus.dec ? {N{1'b1}} : {N{1'b0}};
        end
      end else if (bus.dec) begin
        count_next = count_q - 1'b1;
      end else begin
        count_next = count_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset. In ovf_sticky, a new limit
  // event outranks a clear issued in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pre_cnt <= pre_cnt_next;
      count_q <= count_next;
      tc_q    <= limit_event;
      if (limit_event) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_flags) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.threshold  = (count_q == bus.threshold_value);
  assign bus.tc_pulse   = tc_q;
  assign bus.ovf_sticky = ovf_q;

endmodule

// File: tb/tb_updown_prescaled_counter.sv
// Bench for updown_prescaled_counter. It drives a 32-bit instance and a 4-bit
// instance with the same stimulus and compares both against an arithmetic
// reference model. It also checks a fixed table of small-width corner cases
// and a few hand-written 32-bit prescaler/load sequences.
module tb_updown_prescaled_counter;

  typedef struct {
    bit          rst;
    bit          en;
    bit          dc;
    bit          ld;
    logic [31:0] lv;
    bit          sat;
    logic [3:0]  ps;
    bit          clr;
    logic [31:0] thr;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [3:0] e_cnt;
    bit         e_tc;
    bit         e_ovf;
    bit         e_thr;
  } vec_t;

  logic  clock = 1'b0;
  logic  reset;
  stim_t cur;

  int total = 0;
  int bad   = 0;

  longint modulus [2];
  longint m_count [2];
  int     m_pre   [2];
  bit     m_tc    [2];
  bit     m_ovf   [2];

  updown_prescaled_counter_if #(.N(32), .PRESCALE_W(4)) ifa ();
  updown_prescaled_counter_if #(.N(4),  .PRESCALE_W(4)) ifb ();

  updown_prescaled_counter #(.N(32), .PRESCALE_W(4)) dut_a (
    .clock(clock),
    .reset(reset),
    .bus  (ifa)
  );

  updown_prescaled_counter #(.N(4), .PRESCALE_W(4)) dut_b (
    .clock(clock),
    .reset(reset),
    .bus  (ifb)
  );

  always #5 clock = ~clock;

  assign reset               = cur.rst;
  assign ifa.enable          = cur.en;
  assign ifa.dec             = cur.dc;
  assign ifa.load            = cur.ld;
  assign ifa.load_value      = cur.lv;
  assign ifa.threshold_value = cur.thr;
  assign ifa.sat_mode        = cur.sat;
  assign ifa.prescale        = cur.ps;
  assign ifa.clr_flags       = cur.clr;
  assign ifb.enable          = cur.en;
  assign ifb.dec             = cur.dc;
  assign ifb.load            = cur.ld;
  assign ifb.load_value      = cur.lv[3:0];
  assign ifb.threshold_value = cur.thr[3:0];
  assign ifb.sat_mode        = cur.sat;
  assign ifb.prescale        = cur.ps;
  assign ifb.clr_flags       = cur.clr;

  task automatic compare(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model: counts are plain integers modulo 2^N, and the prescaler
  // is "enabled cycles since the last restart" modulo 16.
  task automatic modelTick();
    bit stepping;
    bit limit;
    for (int i = 0; i < 2; i++) begin
      if (cur.rst) begin
        m_count[i] = 0;
        m_pre[i]   = 0;
        m_tc[i]    = 0;
        m_ovf[i]   = 0;
      end else begin
        stepping = cur.en && !cur.ld && (m_pre[i] == int'(cur.ps));
        limit    = 0;
        if (cur.ld) begin
          m_count[i] = longint'({32'd0, cur.lv}) % modulus[i];
        end else if (stepping) begin
          if (!cur.dc) begin
            limit = (m_count[i] == modulus[i] - 1);
            if (!(limit && cur.sat)) m_count[i] = (m_count[i] + 1) % modulus[i];
          end else begin
            limit = (m_count[i] == 0);
            if (!(limit && cur.sat)) m_count[i] = (m_count[i] - 1 + modulus[i]) % modulus[i];
          end
        end
        if (cur.ld) m_pre[i] = 0;
        else if (cur.en) m_pre[i] = stepping ? 0 : (m_pre[i] + 1) % 16;
        m_tc[i] = limit;
        if (limit) m_ovf[i] = 1;
        else if (cur.clr) m_ovf[i] = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    longint thr_b;
    thr_b = longint'({60'd0, cur.thr[3:0]});
    compare($sformatf("%s a.count", tag), longint'({32'd0, ifa.count}), m_count[0]);
    compare($sformatf("%s a.tc", tag), longint'(ifa.tc_pulse), longint'(m_tc[0]));
    compare($sformatf("%s a.ovf", tag), longint'(ifa.ovf_sticky), longint'(m_ovf[0]));
    compare($sformatf("%s a.thr", tag), longint'(ifa.threshold),
            longint'(m_count[0] == longint'({32'd0, cur.thr})));
    compare($sformatf("%s b.count", tag), longint'({60'd0, ifb.count}), m_count[1]);
    compare($sformatf("%s b.tc", tag), longint'(ifb.tc_pulse), longint'(m_tc[1]));
    compare($sformatf("%s b.ovf", tag), longint'(ifb.ovf_sticky), longint'(m_ovf[1]));
    compare($sformatf("%s b.thr", tag), longint'(ifb.threshold), longint'(m_count[1] == thr_b));
  endtask

  // Drive one cycle of inputs, let the edge pass, then check just after it.
  task automatic applyStimulus(input stim_t s, input string tag);
    cur = s;
    @(posedge clock);
    #1;
    modelTick();
    checkOutput(tag);
  endtask

  function automatic vec_t mk(bit rst, bit en, bit dc, bit ld, logic [31:0] lv, bit sat,
                              bit clr, logic [31:0] thr, logic [3:0] ec, bit etc,
                              bit eovf, bit ethr);
    vec_t v;
    v.s.rst = rst;  v.s.en = en;   v.s.dc = dc;   v.s.ld = ld;   v.s.lv = lv;
    v.s.sat = sat;  v.s.ps = 4'd0; v.s.clr = clr; v.s.thr = thr;
    v.e_cnt = ec;   v.e_tc = etc;  v.e_ovf = eovf; v.e_thr = ethr;
    return v;
  endfunction

  vec_t  vec [$];
  stim_t s;

  initial begin
    modulus[0] = 64'd1 << 32;
    modulus[1] = 16;
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0; m_pre[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end
    s = '{rst: 1, en: 0, dc: 0, ld: 0, lv: 0, sat: 0, ps: 0, clr: 0, thr: 0};
    cur = s;

    // Table on the 4-bit instance (prescale 0): wrap, saturate, flags, threshold.
    //          rst en dc ld lv sat clr thr | cnt tc ovf thr
    vec.push_back(mk(1, 0, 0, 0,  0, 0, 0, 7,  0, 0, 0, 0));
    vec.push_back(mk(1, 0, 0, 0,  0, 0, 0, 7,  0, 0, 0, 0));
    vec.push_back(mk(0, 0, 0, 1, 14, 0, 0, 7, 14, 0, 0, 0));
    vec.push_back(mk(0, 1, 0, 0,  0, 0, 0, 7, 15, 0, 0, 0));
    vec.push_back(mk(0, 1, 0, 0,  0, 0, 0, 7,  0, 1, 1, 0));
    vec.push_back(mk(0, 0, 0, 0,  0, 0, 0, 7,  0, 0, 1, 0));
    vec.push_back(mk(0, 0, 0, 1,  1, 0, 0, 7,  1, 0, 1, 0));
    vec.push_back(mk(0, 1, 1, 0,  0, 0, 0, 7,  0, 0, 1, 0));
    vec.push_back(mk(0, 1, 1, 0,  0, 0, 0, 7, 15, 1, 1, 0));
    vec.push_back(mk(0, 0, 0, 0,  0, 0, 1, 7, 15, 0, 0, 0));
    vec.push_back(mk(0, 0, 0, 1, 14, 1, 0, 7, 14, 0, 0, 0));
    vec.push_back(mk(0, 1, 0, 0,  0, 1, 0, 7, 15, 0, 0, 0));
    vec.push_back(mk(0, 1, 0, 0,  0, 1, 0, 7, 15, 1, 1, 0));
    vec.push_back(mk(0, 1, 0, 0,  0, 1, 0, 7, 15, 1, 1, 0));
    vec.push_back(mk(0, 0, 0, 0,  0, 1, 1, 7, 15, 0, 0, 0));
    vec.push_back(mk(0, 0, 0, 1,  0, 1, 0, 7,  0, 0, 0, 0));
    vec.push_back(mk(0, 1, 1, 0,  0, 1, 1, 7,  0, 1, 1, 0));
    vec.push_back(mk(0, 1, 1, 0,  0, 1, 0, 7,  0, 1, 1, 0));
    vec.push_back(mk(0, 0, 0, 0,  0, 1, 1, 7,  0, 0, 0, 0));
    vec.push_back(mk(0, 0, 0, 1,  5, 0, 0, 7,  5, 0, 0, 0));
    vec.push_back(mk(0, 1, 0, 0,  0, 0, 0, 7,  6, 0, 0, 0));
    vec.push_back(mk(0, 1, 0, 0,  0, 0, 0, 7,  7, 0, 0, 1));
    vec.push_back(mk(0, 1, 0, 0,  0, 0, 0, 7,  8, 0, 0, 0));
    vec.push_back(mk(0, 0, 0, 0,  0, 0, 0, 8,  8, 0, 0, 1));
    vec.push_back(mk(0, 1, 0, 1,  3, 0, 0, 8,  3, 0, 0, 0));
    vec.push_back(mk(1, 1, 0, 1,  9, 0, 0, 8,  0, 0, 0, 0));

    foreach (vec[k]) begin
      applyStimulus(vec[k].s, $sformatf("vec%0d", k));
      compare($sformatf("vec%0d tbl.count", k), longint'({60'd0, ifb.count}),
              longint'({60'd0, vec[k].e_cnt}));
      compare($sformatf("vec%0d tbl.tc", k), longint'(ifb.tc_pulse), longint'(vec[k].e_tc));
      compare($sformatf("vec%0d tbl.ovf", k), longint'(ifb.ovf_sticky), longint'(vec[k].e_ovf));
      compare($sformatf("vec%0d tbl.thr", k), longint'(ifb.threshold), longint'(vec[k].e_thr));
    end

    // Basic up count on the 32-bit instance: 1..5 after reset.
    s = '{rst: 1, en: 0, dc: 0, ld: 0, lv: 0, sat: 0, ps: 0, clr: 0, thr: 32'hFFFF_0000};
    applyStimulus(s, "basic rst");
    applyStimulus(s, "basic rst");
    s.rst = 0; s.en = 1;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(s, "basic");
      compare($sformatf("basic const%0d", k), longint'({32'd0, ifa.count}), longint'(k));
    end

    // Prescale 3: steps on enabled cycles 4, 8, 12, then a 2-cycle pause.
    s.rst = 1; s.en = 0; s.ps = 4'd3;
    applyStimulus(s, "pre rst");
    s.rst = 0; s.en = 1;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(s, "pre");
      compare($sformatf("pre const%0d", k), longint'({32'd0, ifa.count}), longint'(k / 4));
    end
    s.en = 0;
    applyStimulus(s, "pre pause");
    applyStimulus(s, "pre pause");
    s.en = 1;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(s, "pre resume");
      compare($sformatf("pre resume%0d", k), longint'({32'd0, ifa.count}),
              longint'(k == 4 ? 4 : 3));
    end

    // Load while a step is due: no increment, prescaler restarts.
    for (int k = 0; k < 3; k++) applyStimulus(s, "ldpri prep");
    s.ld = 1; s.lv = 32'd100;
    applyStimulus(s, "ldpri load");
    compare("ldpri const load", longint'({32'd0, ifa.count}), 100);
    s.ld = 0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(s, "ldpri after");
      compare($sformatf("ldpri after%0d", k), longint'({32'd0, ifa.count}),
              longint'(k == 4 ? 101 : 100));
    end

    // Prescale lowered below pre_cnt: prescaler runs round before stepping.
    s.ps = 4'd5;
    for (int k = 0; k < 4; k++) applyStimulus(s, "pchg prep");
    s.ps = 4'd2;
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(s, "pchg");
      compare($sformatf("pchg const%0d", k), longint'({32'd0, ifa.count}),
              longint'(k == 15 ? 102 : 101));
    end

    // Randomized traffic against the model, loads biased toward the limits.
    for (int k = 0; k < 3000; k++) begin
      s.rst = ($urandom_range(0, 63) == 0);
      s.en  = ($urandom_range(0, 3) != 0);
      s.dc  = 1'($urandom_range(0, 1));
      s.ld  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0:       s.lv = 32'd0;
        1:       s.lv = 32'd1;
        2:       s.lv = 32'hFFFF_FFFF;
        3:       s.lv = 32'hFFFF_FFFE;
        default: s.lv = $urandom;
      endcase
      s.sat = 1'($urandom_range(0, 1));
      s.clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) begin
        s.ps = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 1) == 1) s.thr = 32'(m_count[1]);
      else s.thr = $urandom_range(0, 15);
      applyStimulus(s, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_prescaled_counter.md
# updown_prescaled_counter

Parametrised up/down event counter with prescaler, parallel load, wrap/saturate mode, threshold compare and overflow reporting. It is the general-purpose timing/counting block for the lab designs, replacing the free-running up-counter. Typical consumers are display refresh dividers, stopwatch/timer cores and event counters that need a programmable terminal value.

## Interface
- N, 32, counter width in bits (N ≥ 2)
- PRESCALE_W, 8, prescaler width in bits (PRESCALE_W ≥ 1)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  counting enable; gates the prescaler and the count step
- dec  in  1  direction; 0 = up, 1 = down; sampled on step cycles
- load  in  1  parallel load strobe
- load_value  in  N  value written to count on load
- threshold_value  in  N  compare value for threshold
- sat_mode  in  1  0 = wrap at limits, 1 = saturate at limits
- prescale  in  PRESCALE_W  step occurs every prescale+1 enabled cycles
- clr_flags  in  1  clears ovf_sticky
- count  out  N  current counter value (registered)
- threshold  out  1  high while count == threshold_value
- tc_pulse  out  1  one-cycle pulse on a limit event (registered)
- ovf_sticky  out  1  latched limit-event flag (registered)

## Operation
- Internal prescaler register pre_cnt (PRESCALE_W bits).
- step = enable && !load && (pre_cnt == prescale).
- Prescaler: load → pre_cnt = 0. enable && pre_cnt == prescale → pre_cnt = 0. enable otherwise → pre_cnt + 1. !enable → hold.
- Priority per cycle: reset > load > step > hold.
- load: count ← load_value regardless of enable. No tc_pulse. Prescaler restarts.
- Up step, count < 2^N−1: count + 1.
- Down step, count > 0: count − 1.
- Limit event (up at 2^N−1 or down at 0):
  - wrap mode: count wraps to 0 or 2^N−1.
  - saturate mode: count holds.
  - Either mode: tc_pulse = 1 next cycle and ovf_sticky set.
- Arithmetic is N-bit unsigned, and no carry out is kept.
- ovf_sticky: set on a limit event and cleared by clr_flags. If both occur in the same cycle, set wins.
- threshold is a combinational compare of the registered count with the live threshold_value, so a change on threshold_value is reflected in the same cycle.
- dec and sat_mode may change at any time and take effect on the next step.
- prescale change mid-count: the new value is compared immediately. If pre_cnt > the new prescale, pre_cnt continues up to 2^PRESCALE_W−1, wraps to 0 and then matches (no early step).

## Timing
- Reset values: count = 0, pre_cnt = 0, tc_pulse = 0, ovf_sticky = 0. threshold reflects (0 == threshold_value).
- Reset mid-operation clears all state on that edge. Load and step are ignored in that cycle.
- Latency: load or step sampled at edge k produces the new count after edge k. tc_pulse is high in the same cycle that count shows the post-event value.
- With prescale = 0 and enable held high, count changes every cycle.
- With prescale = P, the first step occurs P+1 enabled cycles after reset or load.
- tc_pulse is high for exactly 1 cycle per limit event. In saturate mode with steps continuing at the limit, it pulses on every step.

## Test plan
- Reset/basic up (N=32, prescale=0): hold reset 2 cycles, then enable=1, dec=0 for 5 cycles → count 1,2,3,4,5. tc_pulse=0, ovf_sticky=0.
- Prescaler: prescale=3, enable=1 → count increments on enabled cycles 4, 8, 12. Dropping enable for 2 cycles delays the next step by 2.
- Wrap (N=4): load 14, up steps → 15, 0 with tc_pulse=1 on 0 and ovf_sticky=1. Load 1, down steps → 0, 15 with tc_pulse=1.
- Saturate (N=4, sat_mode=1): load 14, 3 up steps → 15, 15, 15 with tc_pulse on the 2nd and 3rd steps. Down from 0 holds at 0.
- Load priority: load=1 with load_value=100 while a step is due → count=100 next cycle, no increment, prescaler restarts.
- Threshold/flags: threshold_value=7, count up from 5 → threshold high only while count=7. clr_flags coincident with a limit event → ovf_sticky stays 1. clr_flags alone → 0 next cycle.
